// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: job-level controller for the conv1d CFU datapath.
// It programs conv1d through its cmd/inp0/inp1/ret port and runs one convolution
// per output position. Between positions it advances the ring start position.
// Each result goes out on a valid/ready stream.
// It also shares the conv1d command port with a buffer loader. Loader writes are
// granted only while no computation is in flight.
module conv1d_sequencer #(
  parameter int INT32_SIZE    = 32,
  parameter int KERNEL_LENGTH = 8,
  parameter int COUNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [COUNT_W-1:0]    job_count,
  input  logic [2:0]            job_start_x,
  input  logic [INT32_SIZE-1:0] job_depth,
  input  logic [INT32_SIZE-1:0] job_offset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_sel,
  input  logic [INT32_SIZE-1:0] wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  adv_valid,
  output logic                  adv_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [INT32_SIZE-1:0] res_data,
  output logic                  job_done,
  output logic                  busy,
  output logic                  conv_en,
  output logic [6:0]            conv_cmd,
  output logic [INT32_SIZE-1:0] conv_inp0,
  output logic [INT32_SIZE-1:0] conv_inp1,
  input  logic [INT32_SIZE-1:0] conv_ret
);

  typedef enum logic [3:0] {
    IDLE, CFG_OFF, CFG_DEP, SETX, START, POLL, READ, CAPTURE, WAIT_COL
  } state_e;

  state_e                state_q, state_d;
  logic [INT32_SIZE-1:0] depth_q, depth_d;
  logic [INT32_SIZE-1:0] offset_q, offset_d;
  logic [COUNT_W-1:0]    rem_q, rem_d;
  logic [2:0]            cur_x_q, cur_x_d;
  logic                  primed_q, primed_d;
  logic                  res_valid_q, res_valid_d;
  logic [INT32_SIZE-1:0] res_data_q, res_data_d;
  logic                  job_done_q, job_done_d;

  logic [COUNT_W-1:0]    rem_dec;
  logic [2:0]            cur_x_inc;

  assign rem_dec   = rem_q - COUNT_W'(1);
  assign cur_x_inc = (cur_x_q == 3'(KERNEL_LENGTH - 1)) ? 3'd0 : cur_x_q + 3'd1;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      offset_q    <= '0;
      rem_q       <= '0;
      cur_x_q     <= '0;
      primed_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      offset_q    <= offset_d;
      rem_q       <= rem_d;
      cur_x_q     <= cur_x_d;
      primed_q    <= primed_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      job_done_q  <= job_done_d;
    end
  end

  // Next-state and datapath updates; a CAPTURE load overrides a same-cycle drain
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    offset_d    = offset_q;
    rem_d       = rem_q;
    cur_x_d     = cur_x_q;
    primed_d    = primed_q;
    res_data_d  = res_data_q;
    job_done_d  = 1'b0;
    res_valid_d = res_valid_q && !res_ready;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          depth_d  = job_depth;
          offset_d = job_offset;
          rem_d    = job_count;
          cur_x_d  = job_start_x;
          if (job_count == '0) job_done_d = 1'b1;
          else                 state_d    = CFG_OFF;
        end
      end
      CFG_OFF: state_d = CFG_DEP;
      CFG_DEP: state_d = SETX;
      SETX:    state_d = START;
      START: begin
        primed_d = 1'b0;
        state_d  = POLL;
      end
      POLL: begin
        primed_d = 1'b1;
        if (primed_q && conv_ret[0]) state_d = READ;
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        if (!res_valid_q || res_ready) begin
          res_valid_d = 1'b1;
          res_data_d  = conv_ret;
          rem_d       = rem_dec;
          cur_x_d     = cur_x_inc;
          if (rem_dec == '0) begin
            job_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_COL;
          end
        end
      end
      WAIT_COL: begin
        if (adv_valid && !wr_valid) state_d = SETX;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command-port and handshake outputs decoded from the current state
  always_comb begin
    conv_en   = 1'b0;
    conv_cmd  = 7'd0;
    conv_inp0 = '0;
    conv_inp1 = '0;
    job_ready = 1'b0;
    wr_ready  = 1'b0;
    adv_ready = 1'b0;
    case (state_q)
      IDLE, WAIT_COL: begin
        wr_ready  = 1'b1;
        job_ready = (state_q == IDLE);
        adv_ready = (state_q == WAIT_COL) && !wr_valid;
        if (wr_valid) begin
          conv_en   = 1'b1;
          conv_cmd  = wr_sel ? 7'd2 : 7'd1;
          conv_inp0 = wr_addr;
          conv_inp1 = INT32_SIZE'(wr_data);
        end
      end
      CFG_OFF: begin
        conv_en   = 1'b1;
        conv_cmd  = 7'd3;
        conv_inp1 = offset_q;
      end
      CFG_DEP: begin
        conv_en   = 1'b1;
        conv_cmd  = 7'd5;
        conv_inp1 = depth_q;
      end
      SETX: begin
        conv_en   = 1'b1;
        conv_cmd  = 7'd8;
        conv_inp1 = INT32_SIZE'(cur_x_q);
      end
      START: begin
        conv_en  = 1'b1;
        conv_cmd = 7'd6;
      end
      POLL: begin
        conv_en  = 1'b1;
        conv_cmd = 7'd9;
      end
      READ: begin
        conv_en  = 1'b1;
        conv_cmd = 7'd7;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign job_done  = job_done_q;

endmodule
